beam_sum_sequencer: RTL

- Time-shares one external 18-bit complex adder to accumulate NUM_CH weighted channel samples into one beam output sample per frame.
- Sits between the per-channel complex weight multipliers and the beam output stage.
- Drives the adder operands, captures the adder sum, saturates on overflow, and presents the frame result on a valid/ready output.

---
 rtl/beam_sum_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/beam_sum_sequencer.sv
// Beam summation sequencer: accumulates NUM_CH complex channel samples per frame
// through one shared external adder, saturating on overflow.
module beam_sum_sequencer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned W      = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_i,
  input  logic signed [W-1:0] in_q,
  input  logic                frame_abort,
  output logic signed [W-1:0] add_a_i,
  output logic signed [W-1:0] add_a_q,
  output logic signed [W-1:0] add_b_i,
  output logic signed [W-1:0] add_b_q,
  input  logic signed [W-1:0] add_s_i,
  input  logic signed [W-1:0] add_s_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_i,
  output logic signed [W-1:0] out_q,
  output logic                out_ovf,
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(NUM_CH + 1);
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic [CNT_W-1:0]      ch_cnt_q, ch_cnt_d;
  logic                  ovf_sticky_q, ovf_sticky_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [W-1:0]   out_i_q, out_i_d, out_q_q, out_q_d;
  logic                  out_ovf_q, out_ovf_d;

  logic                  accept, last_ch, ovf_i, ovf_q;
  logic signed [W-1:0]   sat_i, sat_q;

  assign in_ready = (state_q == ACCUM) && !frame_abort;
  assign accept   = in_valid && in_ready;
  assign last_ch  = (ch_cnt_q == CNT_W'(NUM_CH - 1));
  assign busy     = (ch_cnt_q != '0);

  assign add_a_i = acc_i_q;
  assign add_a_q = acc_q_q;
  assign add_b_i = in_valid ? in_i : '0;
  assign add_b_q = in_valid ? in_q : '0;

  // Signed overflow: operands agree in sign but the returned sum does not.
  assign ovf_i = (acc_i_q[W-1] == add_b_i[W-1]) && (add_s_i[W-1] != acc_i_q[W-1]);
  assign ovf_q = (acc_q_q[W-1] == add_b_q[W-1]) && (add_s_q[W-1] != acc_q_q[W-1]);
  assign sat_i = ovf_i ? (acc_i_q[W-1] ? SAT_MIN : SAT_MAX) : add_s_i;
  assign sat_q = ovf_q ? (acc_q_q[W-1] ? SAT_MIN : SAT_MAX) : add_s_q;

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_q     = out_q_q;
  assign out_ovf   = out_ovf_q;

  // Next-state: accumulate, complete a frame into the output register, or drain HOLD.
  always_comb begin
    state_d      = state_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    ch_cnt_d     = ch_cnt_q;
    ovf_sticky_d = ovf_sticky_q;
    out_valid_d  = out_valid_q;
    out_i_d      = out_i_q;
    out_q_d      = out_q_q;
    out_ovf_d    = out_ovf_q;
    case (state_q)
      ACCUM: begin
        if (frame_abort) begin
          acc_i_d      = '0;
          acc_q_d      = '0;
          ch_cnt_d     = '0;
          ovf_sticky_d = 1'b0;
        end else if (accept) begin
          if (last_ch) begin
            out_i_d      = sat_i;
            out_q_d      = sat_q;
            out_ovf_d    = ovf_sticky_q | ovf_i | ovf_q;
            out_valid_d  = 1'b1;
            state_d      = HOLD;
            acc_i_d      = '0;
            acc_q_d      = '0;
            ch_cnt_d     = '0;
            ovf_sticky_d = 1'b0;
          end else begin
            acc_i_d      = sat_i;
            acc_q_d      = sat_q;
            ch_cnt_d     = ch_cnt_q + CNT_W'(1);
            ovf_sticky_d = ovf_sticky_q | ovf_i | ovf_q;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ACCUM;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      ch_cnt_q     <= '0;
      ovf_sticky_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      ch_cnt_q     <= ch_cnt_d;
      ovf_sticky_q <= ovf_sticky_d;
      out_valid_q  <= out_valid_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      out_ovf_q    <= out_ovf_d;
    end
  end

endmodule
